// File: rtl/mmio_pkg.sv
// mmio_pkg: shared register offsets and hex-to-segment decoding for the MMIO I/O controller.
//   MMIO_STATUS/SWITCH/DISP/DPMASK : word offsets selected by data_addr[3:2]
//   hex2seg                        : 4-bit value -> active-low {a,b,c,d,e,f,g}
package mmio_pkg;

    typedef enum logic [1:0] {
        MMIO_STATUS = 2'd0,
        MMIO_SWITCH = 2'd1,
        MMIO_DISP   = 2'd2,
        MMIO_DPMASK = 2'd3
    } mmio_reg_e;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b0000001;
            4'h1: hex2seg = 7'b1001111;
            4'h2: hex2seg = 7'b0010010;
            4'h3: hex2seg = 7'b0000110;
            4'h4: hex2seg = 7'b1001100;
            4'h5: hex2seg = 7'b0100100;
            4'h6: hex2seg = 7'b0100000;
            4'h7: hex2seg = 7'b0001111;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0000100;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b1100000;
            4'hC: hex2seg = 7'b0110001;
            4'hD: hex2seg = 7'b1000010;
            4'hE: hex2seg = 7'b0110000;
            default: hex2seg = 7'b0111000;
        endcase
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: 2-flop synchroniser plus optional debounce counter for one push-button.
//   clk, rst : clock, synchronous active-high reset
//   i_pin    : raw asynchronous button, active-high
//   o_level  : debounced level
//   o_rise   : one-cycle pulse, high in the cycle whose closing edge raises o_level
// Macro MMIO_DEBOUNCE_EN: when defined, the level must stay stable DEBOUNCE_CYCLES
// cycles before it is accepted; otherwise the level is the synchroniser output.
module mmio_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [1:0] r_sync;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_pin};
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_done;

    // The count tracks consecutive cycles the synchronised pin disagrees with the
    // accepted level; any agreeing cycle restarts it, which rejects short glitches.
    assign w_done = (r_sync[1] != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_cnt   <= (r_sync[1] == r_level || w_done) ? '0 : r_cnt + 1'b1;
            r_level <= w_done ? r_sync[1] : r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_done & r_sync[1];
`else
    // Rise is flagged one stage early so the event lands on the same edge the level rises.
    assign o_level = r_sync[1];
    assign o_rise  = r_sync[0] & ~r_sync[1];
`endif

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O window with button event flags, switches and a
// multiplexed seven-segment display, for the single-cycle MIPS data bus.
//   clk, rst          : clock, synchronous active-high reset
//   write_EN          : CPU store strobe
//   data_addr         : CPU byte address
//   write_data        : store data
//   read_data         : combinational I/O read data, 0 when io_sel=0
//   io_sel            : data_addr falls in the 16-byte window at IO_BASE
//   buttonL, buttonR  : raw push-buttons, active-high
//   switch            : raw switches
//   AN, DP, A2G       : active-low digit enables, decimal point, segments {a..g}
// Macro MMIO_DEBOUNCE_EN: enables the button debounce counters.
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE         = 32'h0000_0080,
    parameter int          NUM_DIGITS      = 8,
    parameter int          SW_WIDTH        = 16,
    parameter int          DEBOUNCE_CYCLES = 20,
    parameter int          SCAN_DIV        = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_EN,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                io_sel,
    input  logic                buttonL,
    input  logic                buttonR,
    input  logic [SW_WIDTH-1:0] switch,
    output logic [7:0]          AN,
    output logic                DP,
    output logic [6:0]          A2G
);

    localparam int DW = NUM_DIGITS * 4;
    localparam int PW = $clog2(SCAN_DIV + 1);

    mmio_reg_e             w_off;
    logic                  w_wr;
    logic [1:0]            w_rise;
    logic [1:0]            w_lvl;
    logic [1:0]            w_clr;
    logic                  w_wrap;
    logic [31:0]           w_disp_ext;
    logic [7:0]            w_dpm_ext;
    logic                  w_unused;
    logic [1:0]            r_status;
    logic [DW-1:0]         r_disp;
    logic [NUM_DIGITS-1:0] r_dpmask;
    logic [SW_WIDTH-1:0]   r_sw_s1;
    logic [SW_WIDTH-1:0]   r_sw_s2;
    logic [PW-1:0]         r_pre;
    logic [2:0]            r_idx;

    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .rst(rst), .i_pin(buttonL), .o_level(w_lvl[0]), .o_rise(w_rise[0])
    );

    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .rst(rst), .i_pin(buttonR), .o_level(w_lvl[1]), .o_rise(w_rise[1])
    );

    assign io_sel     = data_addr[31:4] == IO_BASE[31:4];
    assign w_off      = mmio_reg_e'(data_addr[3:2]);
    assign w_wr       = write_EN & io_sel;
    assign w_clr      = (w_wr && w_off == MMIO_STATUS) ? write_data[1:0] : 2'b00;
    assign w_wrap     = r_pre == PW'(SCAN_DIV - 1);
    assign w_disp_ext = 32'(r_disp);
    assign w_dpm_ext  = 8'(r_dpmask);
    assign w_unused   = ^{data_addr[1:0], w_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
            r_disp   <= '0;
            r_dpmask <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_pre    <= '0;
            r_idx    <= '0;
        end else begin
            // A new event outranks a simultaneous write-1-to-clear.
            r_status <= w_rise | (r_status & ~w_clr);
            r_disp   <= (w_wr && w_off == MMIO_DISP) ? write_data[DW-1:0] : r_disp;
            r_dpmask <= (w_wr && w_off == MMIO_DPMASK) ? write_data[NUM_DIGITS-1:0] : r_dpmask;
            r_sw_s1  <= switch;
            r_sw_s2  <= r_sw_s1;
            r_pre    <= w_wrap ? '0 : r_pre + 1'b1;
            r_idx    <= !w_wrap ? r_idx : (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
        end
    end

    assign read_data = !io_sel                ? 32'd0 :
                       w_off == MMIO_STATUS   ? {30'd0, r_status} :
                       w_off == MMIO_SWITCH   ? 32'(r_sw_s2) :
                       w_off == MMIO_DISP     ? w_disp_ext :
                                                32'(r_dpmask);

    assign AN  = ~(8'd1 << r_idx);
    assign A2G = hex2seg(w_disp_ext[{r_idx, 2'b00} +: 4]);
    assign DP  = ~w_dpm_ext[r_idx];

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: self-checking bench for mmio_io_ctrl with a behavioural model.
module tb_mmio_io_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0080;
    localparam int ND = 4;
    localparam int DB = 4;
    localparam int SD = 3;
`ifdef MMIO_DEBOUNCE_EN
    localparam int WIN = DB;
    localparam int LAG = 2;
`else
    localparam int WIN = 1;
    localparam int LAG = 1;
`endif
    localparam int LAT = LAG + WIN;

    logic        clk = 0;
    logic        rst = 1;
    logic        write_EN = 0;
    logic [31:0] data_addr = 0;
    logic [31:0] write_data = 0;
    logic [31:0] read_data;
    logic        io_sel;
    logic        buttonL = 0;
    logic        buttonR = 0;
    logic [15:0] switch = 0;
    logic [7:0]  AN;
    logic        DP;
    logic [6:0]  A2G;

    int n_checks = 0;
    int n_errors = 0;

    mmio_io_ctrl #(
        .IO_BASE(BASE), .NUM_DIGITS(ND), .SW_WIDTH(16), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .rst(rst), .write_EN(write_EN), .data_addr(data_addr),
        .write_data(write_data), .read_data(read_data), .io_sel(io_sel),
        .buttonL(buttonL), .buttonR(buttonR), .switch(switch),
        .AN(AN), .DP(DP), .A2G(A2G)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // model state
    logic [15:0] hl = 0, hr = 0;
    logic        ll = 0, lr = 0;
    logic [1:0]  st = 0;
    logic [15:0] disp = 0;
    logic [3:0]  dpm = 0;
    logic [15:0] sw1 = 0, sw2 = 0;
    int          tick = 0;
    logic        valid = 0;

    logic        m_sel;
    logic [1:0]  m_off;
    logic        m_wr;
    assign m_sel = data_addr[31:4] == BASE[31:4];
    assign m_off = data_addr[3:2];
    assign m_wr  = write_EN && m_sel;

    // True when the accepted window of pin samples (oldest history bits) all equal v.
    function automatic bit win_all(logic [15:0] h, bit v);
        for (int j = LAG - 1; j <= LAG + WIN - 2; j++)
            if (h[j] !== v) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hl <= 0; hr <= 0; ll <= 0; lr <= 0; st <= 0;
            disp <= 0; dpm <= 0; sw1 <= 0; sw2 <= 0; tick <= 0; valid <= 1;
        end else begin
            hl <= {hl[14:0], buttonL};
            hr <= {hr[14:0], buttonR};
            ll <= win_all(hl, 1) ? 1'b1 : win_all(hl, 0) ? 1'b0 : ll;
            lr <= win_all(hr, 1) ? 1'b1 : win_all(hr, 0) ? 1'b0 : lr;
            st[0] <= (win_all(hl, 1) && !ll) || (st[0] && !(m_wr && m_off == 0 && write_data[0]));
            st[1] <= (win_all(hr, 1) && !lr) || (st[1] && !(m_wr && m_off == 0 && write_data[1]));
            disp <= (m_wr && m_off == 2) ? write_data[15:0] : disp;
            dpm  <= (m_wr && m_off == 3) ? write_data[3:0] : dpm;
            sw1  <= switch;
            sw2  <= sw1;
            tick <= tick + 1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            int dig;
            logic [31:0] exp_rd;
            dig = (tick / SD) % ND;
            exp_rd = !m_sel ? 32'd0 : m_off == 0 ? {30'd0, st} : m_off == 1 ? {16'd0, sw2} :
                     m_off == 2 ? {16'd0, disp} : {28'd0, dpm};
            check("io_sel", {31'd0, io_sel}, {31'd0, m_sel});
            check("read_data", read_data, exp_rd);
            check("AN", {24'd0, AN}, {24'd0, 8'hFF ^ 8'(1 << dig)});
            check("A2G", {25'd0, A2G}, {25'd0, seg_tab[4'((disp >> (4 * dig)) & 16'hF)]});
            check("DP", {31'd0, DP}, {31'd0, ~dpm[dig]});
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        data_addr = a;
        write_data = d;
        write_EN = 1;
        step(1);
        write_EN = 0;
    endtask

    task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
        data_addr = a;
        #1;
        check(name, read_data, exp);
    endtask

    initial begin
        step(2);
        rst = 0;
        check("rst_AN", {24'd0, AN}, 32'h0000_00FE);
        check("rst_A2G", {25'd0, A2G}, 32'b0000001);
        check("rst_DP", {31'd0, DP}, 32'd1);
        rd("rst_status", BASE, 32'd0);
        rd("rst_disp", BASE + 8, 32'd0);
        rd("rst_dpmask", BASE + 12, 32'd0);

        wr(BASE + 8, 32'h1234_ABCD);
        rd("disp_rb", BASE + 8, 32'h0000_ABCD);
        wr(BASE + 4, 32'hFFFF_FFFF);
        rd("switch_ro", BASE + 4, 32'd0);
        rd("out_window", BASE + 16, 32'd0);
        check("out_window_sel", {31'd0, io_sel}, 32'd0);

        switch = 16'hBEEF;
        step(1);
        rd("switch_1edge", BASE + 4, 32'd0);
        step(1);
        rd("switch_2edge", BASE + 4, 32'h0000_BEEF);

`ifdef MMIO_DEBOUNCE_EN
        buttonL = 1;
        step(3);
        buttonL = 0;
        step(6);
        rd("glitch", BASE, 32'd0);
`endif
        buttonL = 1;
        step(LAT - 1);
        rd("btn_early", BASE, 32'd0);
        step(1);
        rd("btn_on_time", BASE, 32'd1);
        wr(BASE, 32'd1);
        rd("w1c", BASE, 32'd0);

        buttonR = 1;
        step(LAT - 1);
        wr(BASE, 32'd2);
        rd("collision", BASE, 32'd2);
        wr(BASE, 32'd2);
        rd("clear_after", BASE, 32'd0);

        rst = 1;
        step(1);
        rst = 0;
        wr(BASE + 8, 32'h0000_0F1A);
        wr(BASE + 12, 32'h0000_0004);
        check("scan0_AN", {24'd0, AN}, 32'hFE);
        check("scan0_A2G", {25'd0, A2G}, 32'b0001000);
        check("scan0_DP", {31'd0, DP}, 32'd1);
        step(1);
        check("scan1_AN", {24'd0, AN}, 32'hFD);
        check("scan1_A2G", {25'd0, A2G}, 32'b1001111);
        step(2);
        check("scan1_dwell", {24'd0, AN}, 32'hFD);
        step(1);
        check("scan2_AN", {24'd0, AN}, 32'hFB);
        check("scan2_A2G", {25'd0, A2G}, 32'b0111000);
        check("scan2_DP", {31'd0, DP}, 32'd0);
        step(3);
        check("scan3_AN", {24'd0, AN}, 32'hF7);
        check("scan3_A2G", {25'd0, A2G}, 32'b0000001);
        check("scan3_DP", {31'd0, DP}, 32'd1);
        step(3);
        check("scan_wrap_AN", {24'd0, AN}, 32'hFE);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
